// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers returned words in an
// in-order FIFO and presents {instr, pc} to decode. Redirects discard wrong-path words.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] aq_wr_q, aq_wr_d;
   logic [PW-1:0] aq_rd_q, aq_rd_d;

   logic [31:0] fifo_instr_q [FIFO_DEPTH];
   logic [31:0] fifo_pc_q    [FIFO_DEPTH];
   logic [31:0] aq_q         [FIFO_DEPTH];

   logic [CW:0] credit_sum;
   logic        grant;
   logic        rsp;
   logic        push;
   logic        pop;
   logic        unused_pc_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Credit rule: every request in flight already owns a FIFO slot, so a push never overflows.
   assign credit_sum = {1'b0, outst_q} + {1'b0, cnt_q};
   assign imem_req   = !rst && !redirect && (credit_sum < (CW+1)'(FIFO_DEPTH));
   assign imem_addr  = pc_q;
   assign grant      = imem_req && imem_gnt;
   assign rsp        = imem_rvalid && (outst_q != '0);
   assign push       = rsp && (drop_q == '0) && !redirect;

   assign id_valid = (cnt_q != '0);
   assign id_instr = id_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
   assign id_pc    = id_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
   assign pop      = id_valid && !stall && !redirect;

   always_comb begin
      pc_d     = pc_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      aq_wr_d  = aq_wr_q;
      aq_rd_d  = aq_rd_q;
      if (redirect) begin
         // Everything still in flight (minus a response landing now) is wrong-path.
         pc_d     = {redirect_pc[31:2], 2'b00};
         outst_d  = outst_q - CW'(rsp);
         drop_d   = outst_q - CW'(rsp);
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         aq_wr_d  = '0;
         aq_rd_d  = '0;
      end else begin
         if (grant) begin
            pc_d    = pc_q + 32'd4;
            aq_wr_d = ptr_inc(aq_wr_q);
         end
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            aq_rd_d  = ptr_inc(aq_rd_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
         end
         cnt_d   = cnt_q + CW'(push) - CW'(pop);
         outst_d = outst_q + CW'(grant) - CW'(rsp);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         aq_wr_q  <= '0;
         aq_rd_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         aq_wr_q  <= aq_wr_d;
         aq_rd_q  <= aq_rd_d;
      end
   end

   // Data storage needs no reset: occupancy is tracked by the counters and pointers.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (grant && (aq_wr_q == PW'(gi))) begin
            aq_q[gi] <= pc_q;
         end
         if (push && (wr_ptr_q == PW'(gi))) begin
            fifo_instr_q[gi] <= imem_rdata;
            fifo_pc_q[gi]    <= aq_q[aq_rd_q];
         end
      end
   end

endmodule
